mdu_alu: RTL
============

// Module: mdu_alu
// PURPOSE
//   Parametrised execute-stage ALU with an integrated multi-cycle multiply/divide unit and HI/LO registers.
//   Single-cycle ops (add/sub/logic/lui/compare) produce aluout combinationally.
//   MULT/DIV ops run for a fixed cycle count under a start/busy handshake.
//   The pipeline stalls on busy. Sits in EX, fed by the controller's op field and forwarded operands.
// PARAMETERS
//   WIDTH       32  operand/result width; even, >=8
//   MUL_CYCLES  5   busy cycles for MULT/MULTU, >=1
//   DIV_CYCLES  10  busy cycles for DIV/DIVU, >=1
// PORTS
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-high
//   op      in   4      operation select (encoding below)
//   a       in   WIDTH  operand 1 (rs)
//   b       in   WIDTH  operand 2 (rt / extended imm)
//   start   in   1      qualifies op 8..13 for issue
//   aluout  out  WIDTH  result, combinational
//   eq      out  1      a == b, combinational
//   busy    out  1      MDU operation in flight, registered
// BEHAVIOUR
//   - op: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR.
//     5 LUI {b[WIDTH/2-1:0], WIDTH/2 zeros}.
//     6 SLT signed a<b ->1 else 0. 7 SLTU unsigned.
//   - op: 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MTHI, 13 MTLO.
//     14 MFHI aluout=HI. 15 MFLO aluout=LO.
//   - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
//   - aluout for op 8..13 = 0. No inferred latch for any op.
//   - FSM IDLE/BUSY. Issue = start & ~busy & op in 8..11 at edge T0:
//     - latch a, b, op; load cnt=N (MUL_CYCLES or DIV_CYCLES); go BUSY.
//     - busy=1 for exactly N cycles after T0.
//     - HI/LO are written on the same edge that busy falls (T0+N); IDLE.
//     - Result is computed from the latched operands; later changes to a/b do not affect it.
//   - MTHI/MTLO: start & ~busy -> HI (or LO) = a at the next edge, no busy.
//   - start while busy (any op): ignored; in-flight op unaffected.
//   - start with op <8 or op 14/15: ignored; no state change.
//   - MFHI/MFLO while busy: return the current (old) HI/LO.
//     Stalling is the hazard unit's job.
//   - MULT/MULTU: {HI,LO} = full 2*WIDTH product, signed/unsigned.
//   - DIV: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
//     MIN_INT / -1 -> LO=MIN_INT, HI=0.
//   - DIV/DIVU with divisor 0: busy for full DIV_CYCLES, then HI/LO unchanged.
//   - reset: HI=0, LO=0, busy=0, cnt=0, FSM IDLE.
//     Reset mid-operation aborts it; no HI/LO write.
//   - Simultaneous reset & start: reset wins.
//   - Back-to-back: a new issue is accepted on the edge after busy falls (busy=0 that cycle).
// TESTING
//   1. ADD 0x7FFFFFFF+1 -> 0x80000000; SUB 5-7 -> 0xFFFFFFFE; LUI b=0x1234 -> 0x12340000.
//   2. SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same -> 0; eq a=b=0xA5 -> 1.
//   3. MULT -3*7, start 1 cycle -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//      MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
//   4. DIV -7/2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      DIVU 7/0 -> busy 10 cycles, HI/LO unchanged.
//      0x80000000 DIV -1 -> LO=0x80000000, HI=0.
//   5. MTHI/MULT issued while busy -> ignored.
//      MFLO during busy -> old LO.
//      Change a/b mid-op -> result unaffected.
//   6. reset at 3rd busy cycle of MULT -> next cycle busy=0, HI=LO=0.
//      A subsequent MULT completes normally.

Source files
------------

// File: rtl/mdu_alu.sv
// Execute-stage ALU with a multi-cycle multiply/divide unit and HI/LO registers.
// Single-cycle ops are combinational; MULT/DIV run for a fixed count under start/busy.
module mdu_alu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] aluout,
    output logic             eq,
    output logic             busy
);

    localparam int HALF    = WIDTH / 2;
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_LUI  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_MTHI = 4'd12;
    localparam logic [3:0] OP_MTLO = 4'd13;
    localparam logic [3:0] OP_MFHI = 4'd14;
    localparam logic [3:0] OP_MFLO = 4'd15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Full 2*WIDTH product; sign-extending to 2*WIDTH makes a plain modular multiply exact.
    function automatic logic [2*WIDTH-1:0] mul_full(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sgn
    );
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
        ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}. Dividing magnitudes keeps MIN_INT / -1 well defined.
    function automatic logic [2*WIDTH-1:0] div_full(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sgn
    );
        logic             neg_x;
        logic             neg_y;
        logic [WIDTH-1:0] mag_x;
        logic [WIDTH-1:0] mag_y;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        neg_x = sgn & x[WIDTH-1];
        neg_y = sgn & y[WIDTH-1];
        mag_x = neg_x ? (-x) : x;
        mag_y = neg_y ? (-y) : y;
        q     = mag_x / mag_y;
        r     = mag_x % mag_y;
        return {(neg_x ? (-r) : r), ((neg_x ^ neg_y) ? (-q) : q)};
    endfunction

    state_e             state_r;
    state_e             state_n;
    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_n;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   lo_n;
    logic [1:0]         op_r;
    logic [1:0]         op_n;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   a_n;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   b_n;
    logic               issue_s;
    logic [2*WIDTH-1:0] mul_s;
    logic [2*WIDTH-1:0] div_s;
    logic               slt_s;
    logic               sltu_s;

    assign issue_s = start & ~busy_r & (op[3:2] == 2'b10);
    assign mul_s   = mul_full(a_r, b_r, ~op_r[0]);
    assign div_s   = div_full(a_r, b_r, ~op_r[0]);
    assign slt_s   = $signed(a) < $signed(b);
    assign sltu_s  = a < b;
    assign eq      = (a == b);
    assign busy    = busy_r;

    // Single-cycle result mux; MDU issue/move ops return zero.
    always_comb begin
        aluout = {WIDTH{1'b0}};
        case (op)
            OP_ADD:  aluout = a + b;
            OP_SUB:  aluout = a - b;
            OP_AND:  aluout = a & b;
            OP_OR:   aluout = a | b;
            OP_XOR:  aluout = a ^ b;
            OP_LUI:  aluout = {b[HALF-1:0], {HALF{1'b0}}};
            OP_SLT:  aluout = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: aluout = {{(WIDTH-1){1'b0}}, sltu_s};
            OP_MFHI: aluout = hi_r;
            OP_MFLO: aluout = lo_r;
            default: aluout = {WIDTH{1'b0}};
        endcase
    end

    // MDU next-state: issue, countdown, HI/LO write-back and direct moves.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        hi_n    = hi_r;
        lo_n    = lo_r;
        op_n    = op_r;
        a_n     = a_r;
        b_n     = b_r;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    state_n = BUSY;
                    cnt_n   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    op_n    = op[1:0];
                    a_n     = a;
                    b_n     = b;
                end else if (start && (op == OP_MTHI)) begin
                    hi_n = a;
                end else if (start && (op == OP_MTLO)) begin
                    lo_n = a;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_n = IDLE;
                    cnt_n   = {CNT_W{1'b0}};
                    if (!op_r[1]) begin
                        hi_n = mul_s[2*WIDTH-1:WIDTH];
                        lo_n = mul_s[WIDTH-1:0];
                    end else if (b_r != {WIDTH{1'b0}}) begin
                        hi_n = div_s[2*WIDTH-1:WIDTH];
                        lo_n = div_s[WIDTH-1:0];
                    end else begin
                        hi_n = hi_r;
                    end
                end else begin
                    cnt_n = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = {CNT_W{1'b0}};
            end
        endcase
    end

    // MDU state, operand latches and HI/LO registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            op_r    <= 2'b00;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n == BUSY);
            cnt_r   <= cnt_n;
            hi_r    <= hi_n;
            lo_r    <= lo_n;
            op_r    <= op_n;
            a_r     <= a_n;
            b_r     <= b_n;
        end
    end

endmodule
